// File: rtl/uart_echo_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_echo_fifo
//  Description : Buffered UART echo engine. Good received bytes are queued in
//                a FIFO, transformed at pop time (pass / invert / case swap /
//                silent) and relaunched to the uart core with a
//                start/busy handshake. Exposes last byte, FIFO level, a sticky
//                overflow flag and saturating statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [1:0]                      mode,
   input  logic                            clear_stats,
   input  logic                            rx_valid,
   input  logic [DATA_WIDTH-1:0]           rx_data,
   input  logic                            rx_error,
   input  logic                            tx_busy,
   output logic                            tx_start,
   output logic [DATA_WIDTH-1:0]           tx_data,
   output logic [DATA_WIDTH-1:0]           last_byte,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow,
   output logic [CNT_WIDTH-1:0]            rx_count,
   output logic [CNT_WIDTH-1:0]            drop_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [PTR_W-1:0]     c_ptr_one  = PTR_W'(1);
   localparam logic [LVL_W-1:0]     c_lvl_one  = LVL_W'(1);
   localparam logic [LVL_W-1:0]     c_lvl_full = LVL_W'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;

   localparam logic [1:0] c_mode_pass   = 2'b00;
   localparam logic [1:0] c_mode_invert = 2'b01;
   localparam logic [1:0] c_mode_swap   = 2'b10;
   localparam logic [1:0] c_mode_silent = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t                  state_q,      state_d;
   logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q,     wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q,     rd_ptr_d;
   logic [LVL_W-1:0]        level_q,      level_d;
   logic                    tx_start_q,   tx_start_d;
   logic [DATA_WIDTH-1:0]   tx_data_q,    tx_data_d;
   logic [DATA_WIDTH-1:0]   last_byte_q,  last_byte_d;
   logic                    overflow_q,   overflow_d;
   logic [CNT_WIDTH-1:0]    rx_count_q,   rx_count_d;
   logic [CNT_WIDTH-1:0]    drop_count_q, drop_count_d;

   logic                    w_empty;
   logic                    w_full;
   logic                    w_push_req;
   logic                    w_push_ok;
   logic                    w_push_rej;
   logic                    w_pop;
   logic [DATA_WIDTH-1:0]   w_head;
   logic [DATA_WIDTH-1:0]   w_swap;
   logic [DATA_WIDTH-1:0]   w_xform;

   assign w_empty    = (level_q == '0);
   assign w_full     = (level_q == c_lvl_full);
   assign w_head     = mem_q[rd_ptr_q];
   assign w_push_req = rx_valid & ~rx_error;
   // A full FIFO still takes a byte when the head leaves on the same edge.
   assign w_push_ok  = w_push_req & (~w_full | w_pop);
   assign w_push_rej = w_push_req & w_full & ~w_pop;
   // Pops only happen from IDLE with an idle core; silent mode drops the byte.
   assign w_pop      = (state_q == ST_IDLE) & ~w_empty & ~tx_busy;

   // ASCII case swap only makes sense for byte-wide data; wider paths pass.
   generate
      if (DATA_WIDTH == 8) begin : g_swap_ascii
         logic w_is_alpha;
         assign w_is_alpha = ((w_head >= 8'h41) && (w_head <= 8'h5A)) ||
                             ((w_head >= 8'h61) && (w_head <= 8'h7A));
         assign w_swap     = w_is_alpha ? (w_head ^ 8'h20) : w_head;
      end else begin : g_swap_pass
         assign w_swap = w_head;
      end
   endgenerate

   // Transform of the FIFO head selected by the mode sampled at pop time.
   always_comb begin
      w_xform = w_head;
      case (mode)
         c_mode_pass:   w_xform = w_head;
         c_mode_invert: w_xform = ~w_head;
         c_mode_swap:   w_xform = w_swap;
         default:       w_xform = w_head;
      endcase
   end

   // FIFO storage, pointers and occupancy update.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (w_push_ok) begin
         mem_d[wr_ptr_q] = rx_data;
         wr_ptr_d        = wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_ptr_one;
      end
      if (w_push_ok && !w_pop) begin
         level_d = level_q + c_lvl_one;
      end else if (!w_push_ok && w_pop) begin
         level_d = level_q - c_lvl_one;
      end
   end

   // Transmit handshake FSM: launch, hold until busy seen, wait for idle.
   always_comb begin
      state_d    = state_q;
      tx_start_d = tx_start_q;
      tx_data_d  = tx_data_q;
      case (state_q)
         ST_IDLE: begin
            tx_start_d = 1'b0;
            if (w_pop && (mode != c_mode_silent)) begin
               tx_data_d  = w_xform;
               tx_start_d = 1'b1;
               state_d    = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (tx_busy) begin
               tx_start_d = 1'b0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            tx_start_d = 1'b0;
            if (!tx_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            tx_start_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   // Last byte, sticky overflow and saturating counters; clear wins.
   always_comb begin
      last_byte_d  = last_byte_q;
      overflow_d   = overflow_q;
      rx_count_d   = rx_count_q;
      drop_count_d = drop_count_q;
      if (w_push_ok) begin
         last_byte_d = rx_data;
         if (rx_count_q != c_cnt_max) begin
            rx_count_d = rx_count_q + c_cnt_one;
         end
      end
      if (w_push_rej) begin
         overflow_d = 1'b1;
      end
      if ((w_push_rej || (rx_valid && rx_error)) && (drop_count_q != c_cnt_max)) begin
         drop_count_d = drop_count_q + c_cnt_one;
      end
      if (clear_stats) begin
         overflow_d   = 1'b0;
         rx_count_d   = '0;
         drop_count_d = '0;
      end
   end

   // Register everything; reset asserts asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= '0;
         last_byte_q  <= '0;
         overflow_q   <= 1'b0;
         rx_count_q   <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         last_byte_q  <= last_byte_d;
         overflow_q   <= overflow_d;
         rx_count_q   <= rx_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign last_byte  = last_byte_q;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign rx_count   = rx_count_q;
   assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Parametrised buffered echo engine between a uart core byte interface and board I/O (LEDs, hex display).
- Received bytes go into a FIFO, pass through a selectable transform, and are retransmitted with a full launch/busy handshake, so back-to-back bytes are never lost while TX is busy.
- Exposes last byte, FIFO level, sticky overflow and saturating statistics counters for display.

Parameters:
- DATA_WIDTH, 8, byte width on RX/TX paths.
- FIFO_DEPTH, 16, entries. Power of two, at least 2.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  2  transform select: 00 pass, 01 bitwise invert, 10 ASCII case swap, 11 silent (no echo)
- clear_stats  input  1  synchronous clear of counters and overflow flag
- rx_valid  input  1  one-cycle pulse from uart core "received"
- rx_data  input  DATA_WIDTH  uart core rx_byte
- rx_error  input  1  uart core recv_error, sampled with rx_valid
- tx_busy  input  1  uart core is_transmitting
- tx_start  output  1  uart core transmit request
- tx_data  output  DATA_WIDTH  byte to transmit
- last_byte  output  DATA_WIDTH  most recent good received byte (untransformed)
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  output  1  sticky: a byte was dropped because the FIFO was full
- rx_count  output  CNT_WIDTH  good bytes received, saturating
- drop_count  output  CNT_WIDTH  bytes dropped (error or overflow), saturating

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, FSM in IDLE.
- Push: on a clk edge with rx_valid=1 and rx_error=0.
  - Accepted if not full, or if full and a pop occurs in the same cycle.
  - Accepted push: rx_count+1 and last_byte updates.
  - Rejected push: overflow set and drop_count+1.
- rx_valid with rx_error=1: nothing stored, drop_count+1, last_byte unchanged.
- mode=11: pushes still occur; bytes are discarded on pop without asserting tx_start. Pop rate is 1 per cycle.
- Transform is applied at pop time. Case swap XORs bit 5 only for 'A'-'Z' and 'a'-'z'; other bytes pass unchanged. For DATA_WIDTH≠8, case swap acts as pass.
- mode is sampled at pop. Changing mode mid-transmission does not alter a byte already launched.
- FSM:
  - IDLE: if FIFO not empty and tx_busy=0, pop, load tx_data with the transformed head, assert tx_start, go to LAUNCH. If mode=11, pop and stay in IDLE.
  - LAUNCH: hold tx_start=1 and tx_data stable until tx_busy=1 is sampled. Then deassert tx_start and go to WAIT.
  - WAIT: stay until tx_busy=0, then go to IDLE.
- Latency: a byte pushed at edge N into an empty FIFO with an idle core gives tx_start=1 after edge N+1.
- tx_data holds its last value when idle.
- fifo_level is registered and reflects push/pop of the same edge. A simultaneous push and pop leaves the level unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full is level==FIFO_DEPTH; empty is level==0.
- Counters saturate at all-ones and never wrap.
- clear_stats zeroes rx_count, drop_count and overflow. It does not affect the FIFO, FSM or last_byte. If an increment occurs in the same cycle, clear wins.
- rst_n asserted mid-transmission: tx_start drops immediately and FIFO contents are lost.

Test Plan:
- Single byte 0x41, mode 00: tx_start asserted 1 cycle after push, tx_data=0x41. After tx_busy rises, tx_start=0. last_byte=0x41, rx_count=1.
- Bytes 0x61, 0x5A, 0x31 in mode 10 with a slow busy model → transmitted 0x41, 0x7A, 0x31 in order, with no second launch while tx_busy=1.
- tx_busy held high; push 17 bytes with DEPTH=16 → fifo_level=16, overflow=1, drop_count=1, rx_count=16. Release busy → 16 bytes echoed in order.
- Full FIFO with push and pop in the same cycle → byte accepted, level stays 16, overflow stays 0.
- rx_valid with rx_error=1, data 0xFF → nothing transmitted, drop_count=1, last_byte unchanged. Then clear_stats → counters 0, overflow 0.
- mode 11 with 3 bytes queued → level drains to 0 in 3 cycles, tx_start never asserts. rst_n pulsed in LAUNCH → tx_start=0 asynchronously, level=0.
